fetch_sequencer: RTL and testbench

Instruction-fetch controller for the 16-bit pipeline. It owns the architectural fetch PC and sequences requests to the instruction memory over a req/ready handshake. It delivers one registered instruction at a time into the IF/ID boundary and honours decode-stage stalls, taken-branch redirects from the branch/PC-control datapath, and HLT detection.

---
 rtl/fetch_sequencer.sv | 107 ++++++++++
 tb/tb_fetch_sequencer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, issues req/ready fetches to
// instruction memory and holds one registered instruction at the IF/ID boundary.
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic [15:0] if_pc_plus2,
    output logic [15:0] pc,
    output logic        halted
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic        valid_q, valid_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] if_pc_q, if_pc_d;
    logic [15:0] if_pc2_q, if_pc2_d;

    logic        buf_free;
    logic        accept;
    logic        accept_hlt;
    logic [15:0] pc_inc;

    // The buffer can take a new instruction when empty or being consumed this cycle.
    assign buf_free   = !valid_q || !stall;
    assign pc_inc     = pc_q + 16'd2;

    // Redirect and reset keep req low so a late imem_ready can never be accepted.
    assign imem_req   = (state_q == FETCH) && buf_free && !redirect && !rst;
    assign imem_addr  = pc_q;
    assign accept     = imem_req && imem_ready;
    assign accept_hlt = accept && (imem_rdata[15:12] == HLT_OPCODE);

    always_comb begin
        // NOTE: every signal written here gets its default first, so no latch is inferred.
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        instr_d  = instr_q;
        if_pc_d  = if_pc_q;
        if_pc2_d = if_pc2_q;

        if (redirect) begin
            // Squash the wrong-path instruction and restart fetch at the target.
            valid_d = 1'b0;
            pc_d    = redirect_pc;
            state_d = FETCH;
        end else if (accept) begin
            valid_d  = 1'b1;
            instr_d  = imem_rdata;
            if_pc_d  = pc_q;
            if_pc2_d = pc_inc;
            if (accept_hlt) begin
                // PC stays on the HLT so a later redirect is the only way forward.
                state_d = HALT;
            end else begin
                pc_d = pc_inc;
            end
        end else if (valid_q && !stall) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            instr_q  <= 16'h0000;
            if_pc_q  <= 16'h0000;
            if_pc2_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            instr_q  <= instr_d;
            if_pc_q  <= if_pc_d;
            if_pc2_q <= if_pc2_d;
        end
    end

    assign if_valid    = valid_q;
    assign if_instr    = instr_q;
    assign if_pc       = if_pc_q;
    assign if_pc_plus2 = if_pc2_q;
    assign pc          = pc_q;
    assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a program-flow model predicts fetch
// requests and the instruction stream; a negedge monitor checks IF/ID delivery.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc_plus2;
    logic [15:0] pc;
    logic        halted;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC  (16'h0000),
        .HLT_OPCODE(4'hF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .if_pc_plus2(if_pc_plus2),
        .pc         (pc),
        .halted     (halted)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] instr;
        int          vis;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    bit          started = 1'b0;

    // Program-flow model: next fetch address, buffer occupancy, halt flag.
    logic [15:0] m_pc = 16'h0000;
    bit          m_full = 1'b0;
    bit          m_halted = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory image: an HLT at every address ending in 0x20, non-HLT words elsewhere.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        logic [15:0] w;
        if (a[7:0] == 8'h20) return {4'hF, a[11:0]};
        w = a * 16'd13 + 16'h1357;
        if (w[15:12] == 4'hF) w[15:12] = 4'h7;
        return w;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // One clock cycle: drive inputs, check fetch-side outputs, advance the model.
    task automatic step(input bit r, input bit s, input bit rd, input logic [15:0] rpc, input bit rdy);
        logic        exp_req;
        logic [15:0] w;
        @(posedge clk);
        #1;
        rst         = r;
        stall       = s;
        redirect    = rd;
        redirect_pc = rpc;
        imem_ready  = rdy;
        imem_rdata  = rdy ? mem_word(imem_addr) : 16'($urandom);
        #1;
        exp_req = !r && !rd && !m_halted && (!m_full || !s);
        check("imem_req", {15'd0, imem_req}, {15'd0, exp_req});
        check("imem_addr", imem_addr, m_pc);
        check("pc", pc, m_pc);
        check("halted", {15'd0, halted}, {15'd0, m_halted});

        if (r) begin
            m_pc = 16'h0000; m_full = 1'b0; m_halted = 1'b0;
        end else if (rd) begin
            m_pc = rpc; m_full = 1'b0; m_halted = 1'b0;
        end else if (exp_req && rdy) begin
            w = mem_word(m_pc);
            sb.push_back('{addr: m_pc, instr: w, vis: cyc + 1});
            m_full = 1'b1;
            if (w[15:12] == 4'hF) m_halted = 1'b1;
            else m_pc = m_pc + 16'd2;
        end else if (!s) begin
            m_full = 1'b0;
        end
    endtask

    // Monitor: compares the IF/ID register against the scoreboard each negedge.
    initial begin
        logic exp_v;
        wait (started);
        forever begin
            @(negedge clk);
            exp_v = (sb.size() > 0) && (sb[0].vis <= cyc);
            check("if_valid", {15'd0, if_valid}, {15'd0, exp_v});
            if (exp_v) begin
                check("if_instr", if_instr, sb[0].instr);
                check("if_pc", if_pc, sb[0].addr);
                check("if_pc_plus2", if_pc_plus2, sb[0].addr + 16'd2);
                if (rst || redirect || !stall) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic [15:0] rpc;
        @(posedge clk);
        started = 1'b1;

        step(1, 0, 0, 16'h0000, 0);
        repeat (4) step(0, 0, 0, 16'h0000, 1);       // 0000, 0002, 0004, 0006
        repeat (3) step(0, 1, 0, 16'h0000, 1);       // stall with buffer full
        step(0, 0, 0, 16'h0000, 1);                   // stall drops, fetch same cycle
        step(0, 0, 1, 16'h0010, 0);
        repeat (2) step(0, 0, 0, 16'h0000, 0);       // two wait cycles at 0x0010
        step(0, 0, 0, 16'h0000, 1);
        step(0, 0, 0, 16'h0000, 0);
        step(0, 0, 1, 16'h0008, 0);
        step(0, 0, 0, 16'h0000, 0);                   // fetch of 0x0008 pending
        step(0, 0, 1, 16'h0040, 1);                   // redirect drops the 0x0008 data
        step(0, 0, 0, 16'h0000, 1);
        step(0, 0, 1, 16'h0020, 0);
        repeat (4) step(0, 0, 0, 16'h0000, 1);       // HLT at 0x0020, fetch stops
        step(0, 0, 1, 16'h0100, 0);
        repeat (2) step(0, 0, 0, 16'h0000, 1);
        step(0, 0, 1, 16'hFFFE, 0);
        step(0, 0, 0, 16'h0000, 1);                   // accept at 0xFFFE wraps pc
        step(0, 1, 0, 16'h0000, 0);
        step(0, 0, 0, 16'h0000, 0);                   // waiting at 0x0000
        step(1, 0, 0, 16'h0000, 1);                   // reset mid-wait, ready ignored
        repeat (2) step(0, 0, 0, 16'h0000, 1);

        repeat (3000) begin
            case ($urandom_range(0, 3))
                0:       rpc = 16'hFFFE;
                1:       rpc = 16'h0020;
                default: rpc = {15'($urandom), 1'b0};
            endcase
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 8, rpc, $urandom_range(0, 99) < 60);
        end

        repeat (2) step(0, 0, 0, 16'h0000, 1);
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
